// File: rtl/radio_rx_burst_sched_if.sv
// Host-side stream command channel into the RX burst scheduler.
// The master issues commands; the slave (scheduler) returns ready.
interface radio_rx_burst_sched_if #(
  parameter int NUM_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_stop;
  logic              cmd_cont;
  logic              cmd_timed;
  logic [63:0]       cmd_time;
  logic [NUM_W-1:0]  cmd_num;

  modport master (
    output cmd_valid, cmd_stop, cmd_cont, cmd_timed, cmd_time, cmd_num,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_stop, cmd_cont, cmd_timed, cmd_time, cmd_num,
    output cmd_ready
  );
endinterface

// File: rtl/radio_rx_burst_sched.sv
// Timed RX burst scheduler: queues stream commands and qualifies the ADC
// strobe into SOB/EOB-marked bursts, flagging late commands and overruns.
module radio_rx_burst_sched #(
  parameter int NIPC    = 1,
  parameter int FIFO_AW = 4,
  parameter int NUM_W   = 32
) (
  input  logic                         radio_clk,
  input  logic                         radio_rst,
  input  logic [63:0]                  radio_time,
  input  logic                         radio_rx_stb,
  radio_rx_burst_sched_if.slave        cmd,
  input  logic                         ovf_in,
  output logic                         out_stb,
  output logic                         out_sob,
  output logic                         out_eob,
  output logic [63:0]                  out_time,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [63:0]                  err_time,
  output logic                         active
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [1:0] ERR_LATE = 2'd1;
  localparam logic [1:0] ERR_OVR  = 2'd2;

  // radio_time already advances by NIPC per word, so scheduling stays per word.
  if (NIPC < 1) begin : g_nipc_unsupported
  end

  typedef struct packed {
    logic             stop;
    logic             cont;
    logic             timed;
    logic [63:0]      start_time;
    logic [NUM_W-1:0] num;
  } cmd_t;

  cmd_t                fifo_mem [DEPTH];
  cmd_t                head;
  cmd_t                wr_ent;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                push, pop, flush, head_vld;

  logic [1:0]          state_q, state_d;
  logic [NUM_W-1:0]    cnt_q, cnt_d;
  logic                cont_q, cont_d;
  logic                first_q, first_d;
  logic                stop_pend_q, stop_pend_d;
  logic [63:0]         wait_time_q, wait_time_d;
  logic                emit;

  logic                out_stb_q, out_stb_d;
  logic                out_sob_q, out_sob_d;
  logic                out_eob_q, out_eob_d;
  logic [63:0]         out_time_q, out_time_d;
  logic                err_valid_q, err_valid_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [63:0]         err_time_q, err_time_d;

  assign push     = cmd.cmd_valid & cmd_ready_q;
  assign head     = fifo_mem[rd_ptr_q];
  assign head_vld = (level_q != '0);

  assign wr_ent.stop       = cmd.cmd_stop;
  assign wr_ent.cont       = cmd.cmd_cont;
  assign wr_ent.timed      = cmd.cmd_timed;
  assign wr_ent.start_time = cmd.cmd_time;
  assign wr_ent.num        = cmd.cmd_num;

  // Scheduler: decides pops/flushes and what the registered outputs carry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cont_d      = cont_q;
    first_d     = first_q;
    stop_pend_d = stop_pend_q;
    wait_time_d = wait_time_q;
    pop         = 1'b0;
    flush       = 1'b0;
    emit        = 1'b0;
    out_stb_d   = 1'b0;
    out_sob_d   = 1'b0;
    out_eob_d   = 1'b0;
    out_time_d  = out_time_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_time_d  = err_time_q;

    case (state_q)
      ST_IDLE: begin
        if (head_vld) begin
          pop = 1'b1;
          if (head.stop) begin
            state_d = ST_IDLE;
          end else if (head.timed && (head.start_time < radio_time)) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_LATE;
            err_time_d  = radio_time;
          end else begin
            cnt_d       = (head.num == '0) ? NUM_W'(1) : head.num;
            cont_d      = head.cont;
            first_d     = 1'b1;
            stop_pend_d = 1'b0;
            wait_time_d = head.start_time;
            state_d     = head.timed ? ST_WAIT : ST_RUN;
          end
        end
      end
      ST_WAIT: begin
        if (ovf_in) begin
          flush = 1'b1;
        end else if (head_vld && head.stop) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else if (radio_rx_stb && (radio_time >= wait_time_q)) begin
          emit = 1'b1;
        end
      end
      ST_RUN: begin
        if (ovf_in) begin
          flush = 1'b1;
        end else begin
          // A stop only ends a continuous burst; the EOB rides on a later strobe.
          if (cont_q && !stop_pend_q && head_vld && head.stop) begin
            pop         = 1'b1;
            stop_pend_d = 1'b1;
          end
          emit = radio_rx_stb;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_OVR;
      err_time_d  = radio_time;
      state_d     = ST_IDLE;
    end

    if (emit) begin
      out_stb_d = 1'b1;
      out_sob_d = first_q;
      first_d   = 1'b0;
      state_d   = ST_RUN;
      if (first_q) begin
        out_time_d = radio_time;
      end
      if (cont_q) begin
        if (stop_pend_q) begin
          out_eob_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end else if (cnt_q == NUM_W'(1)) begin
        out_eob_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cnt_d = cnt_q - NUM_W'(1);
      end
    end
  end

  // Command FIFO pointers; an overrun drops everything queued at once.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = push ? (FIFO_AW+1)'(1) : '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
        2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
    cmd_ready_d = (level_d != (FIFO_AW+1)'(DEPTH));
  end

  always_ff @(posedge radio_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_ent;
    end
  end

  always_ff @(posedge radio_clk) begin
    cnt_q       <= cnt_d;
    wait_time_q <= wait_time_d;
    cont_q      <= cont_d;
  end

  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cmd_ready_q <= 1'b0;
      state_q     <= ST_IDLE;
      first_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      out_stb_q   <= 1'b0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_time_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_time_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      first_q     <= first_d;
      stop_pend_q <= stop_pend_d;
      out_stb_q   <= out_stb_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      out_time_q  <= out_time_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_time_q  <= err_time_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign out_stb       = out_stb_q;
  assign out_sob       = out_sob_q;
  assign out_eob       = out_eob_q;
  assign out_time      = out_time_q;
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;
  assign err_time      = err_time_q;
  assign active        = (state_q != ST_IDLE);

endmodule
